// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage of the multi-cycle RV32I core.
//             - Owns the program counter and presents it to instruction memory.
//             - Captures the returned word into an instruction register.
//             - Hands the instruction to decode with a valid/ready handshake.
//             - Accepts PC redirects from execute (jal, jalr, taken branches).
//
//  Ports    : clk            system clock (rising edge)
//             reset          asynchronous, active-high reset
//             imem_address   instruction address to memory (= pc)
//             imem_data_out  instruction word, valid one cycle after address
//             redirect_valid execute requests a PC change this cycle
//             redirect_pc    redirect target
//             instr_ready    decode consumes the held instruction
//             instr_valid    instruction/pc hold a valid fetched instruction
//             instruction    registered instruction word
//             pc             address of instruction
//             pc_plus4       pc + 4 (link value)
//             fetch_count    completed handshakes (wraps)
//             fetch_fault    misaligned-redirect trap flag
//                            (present only with FETCH_MISALIGN_TRAP_EN)
//
//  Options  : FETCH_MISALIGN_TRAP_EN - when defined, a redirect to a
//             non-word-aligned target traps into a FAULT state that only
//             reset leaves. When undefined, redirect_pc[1:0] is forced to 0.
//
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        fetch_fault,
`endif
    output logic [31:0] fetch_count
);

    localparam logic [31:0] c_PC_STEP    = 32'd4;
    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic [31:0] r_count;

    logic        w_handshake;
    logic [31:0] w_aligned_pc;

    // A handshake only exists while an instruction is being held.
    assign w_handshake  = (r_state == ST_HOLD) && instr_ready;
    assign w_aligned_pc = redirect_pc & c_ALIGN_MASK;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_fault;
    logic w_misaligned;

    assign w_misaligned = |redirect_pc[1:0];
    assign fetch_fault  = r_fault;
`endif

    assign imem_address = r_pc;
    assign pc           = r_pc;
    assign pc_plus4     = r_pc + c_PC_STEP;
    assign instr_valid  = r_valid;
    assign instruction  = r_instr;
    assign fetch_count  = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_REQ;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            r_count <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_fault <= 1'b0;
`endif
        end else if (redirect_valid && (r_state != ST_FAULT)) begin
            // Redirect beats every other transition. A handshake landing in
            // the same cycle still counts, but the pc comes from execute.
            if (w_handshake) begin
                r_count <= r_count + 32'd1;
            end
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_pc <= redirect_pc;
            if (w_misaligned) begin
                r_fault <= 1'b1;
                r_state <= ST_FAULT;
            end else begin
                r_state <= ST_REQ;
            end
`else
            r_pc    <= w_aligned_pc;
            r_state <= ST_REQ;
`endif
        end else begin
            case (r_state)
                ST_REQ: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_instr <= imem_data_out;
                    r_valid <= 1'b1;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        r_pc    <= r_pc + c_PC_STEP;
                        r_valid <= 1'b0;
                        r_count <= r_count + 32'd1;
                        r_state <= ST_REQ;
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                ST_FAULT: begin
                    // Sticky until reset.
                    r_state <= ST_FAULT;
                end
`endif
                default: begin
                    r_state <= ST_REQ;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
